alu_seq_md: RTL

- Parametrised next-generation execute-stage ALU for the pipelined core.
- Performs the single-cycle integer operations at configurable width. Adds iterative (multi-cycle) multiply, divide and remainder.
- Has a registered output and valid/ready handshakes on both sides, so the hazard unit can stall the pipeline on busy.
- Sits between the ID/EX register and the EX/MEM register.

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/alu_seq_md_core.sv | 152 +++++++++++++++
 rtl/alu_seq_md.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the execute-stage ALU: op codes, FSM state
// encoding and the iterative-op classifier.
// Optional feature macro: ALU_SEQ_SIGNED_MD_EN (signed MULH/DIV/REM).
package alu_seq_pkg;

   localparam int unsigned OPC_W = 4;
   typedef logic [OPC_W-1:0] opc_t;

   localparam opc_t OP_ADD   = 4'd0;
   localparam opc_t OP_SUB   = 4'd1;
   localparam opc_t OP_AND   = 4'd2;
   localparam opc_t OP_OR    = 4'd3;
   localparam opc_t OP_GTU   = 4'd4;
   localparam opc_t OP_LTU   = 4'd5;
   localparam opc_t OP_XOR   = 4'd6;
   localparam opc_t OP_LT    = 4'd7;
   localparam opc_t OP_MUL   = 4'd8;
   localparam opc_t OP_MULHU = 4'd9;
   localparam opc_t OP_DIVU  = 4'd10;
   localparam opc_t OP_REMU  = 4'd11;
   localparam opc_t OP_MULH  = 4'd12;
   localparam opc_t OP_DIV   = 4'd13;
   localparam opc_t OP_REM   = 4'd14;
   localparam opc_t OP_UNK   = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic is_iterative(input opc_t op);
      logic it;
      it = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`ifdef ALU_SEQ_SIGNED_MD_EN
      it = it || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
`endif
      return it;
   endfunction

endpackage

// File: rtl/alu_seq_md_core.sv
// alu_seq_md_core
// Iterative multiply / divide datapath. On start the operands are loaded;
// then WIDTH steps of shift-add (multiply) or restoring subtract (divide)
// run, one per clock. done pulses with the final step and res is valid
// in that same cycle, so the caller registers it on the last step edge.
// Ports: clk, rst_n (async active-low), flush (abort), start, op,
//        src_a, src_b (operands), done, res.
// Optional feature macro: ALU_SEQ_SIGNED_MD_EN (signed ops via magnitudes).
module alu_seq_md_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start,
   input  opc_t             op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   logic             active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
   opc_t             op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             dz_q, dz_d;
   // hi: accumulator / partial remainder, lo: multiplier / quotient
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_nx, lo_nx, diff, a_mag, b_mag;
   logic [WIDTH:0]   sum_w, rem_w;
   logic             ge, is_mul;
`ifdef ALU_SEQ_SIGNED_MD_EN
   logic             neg_q, neg_d, sgn, a_neg, b_neg;
`endif

   always_comb begin
      is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);
`ifdef ALU_SEQ_SIGNED_MD_EN
      is_mul = is_mul || (op_q == OP_MULH);
`endif
      sum_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
      rem_w = {hi_q, lo_q[WIDTH-1]};
      ge    = rem_w >= {1'b0, dvs_q};
      // remainder stays below 2^WIDTH after a successful subtract
      diff  = rem_w[WIDTH-1:0] - (ge ? dvs_q : '0);
      if (is_mul) begin
         hi_nx = sum_w[WIDTH:1];
         lo_nx = {sum_w[0], lo_q[WIDTH-1:1]};
      end else begin
         hi_nx = diff;
         lo_nx = {lo_q[WIDTH-2:0], ge};
      end
      cnt_nx = cnt_q + CNT_W'(1);
      done   = active_q && (cnt_nx == CNT_LAST);
   end

   always_comb begin
      res = '0;
      case (op_q)
         OP_MUL:   res = lo_nx;
         OP_MULHU: res = hi_nx;
         OP_DIVU:  res = dz_q ? '1 : lo_nx;
         OP_REMU:  res = dz_q ? a_q : hi_nx;
`ifdef ALU_SEQ_SIGNED_MD_EN
         // high half of the negated double-width product
         OP_MULH:  res = neg_q ? (~hi_nx + WIDTH'(lo_nx == '0)) : hi_nx;
         OP_DIV:   res = dz_q ? '1 : (neg_q ? -lo_nx : lo_nx);
         OP_REM:   res = dz_q ? a_q : (neg_q ? -hi_nx : hi_nx);
`endif
         default:  res = '0;
      endcase
   end

   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dvs_d    = dvs_q;
      a_mag    = src_a;
      b_mag    = src_b;
`ifdef ALU_SEQ_SIGNED_MD_EN
      neg_d = neg_q;
      a_neg = src_a[WIDTH-1];
      b_neg = src_b[WIDTH-1];
      sgn   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      if (sgn && a_neg) a_mag = -src_a;
      if (sgn && b_neg) b_mag = -src_b;
`endif
      if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         op_d     = op;
         a_d      = src_a;
         dz_d     = (src_b == '0);
         hi_d     = '0;
         lo_d     = a_mag;
         dvs_d    = b_mag;
`ifdef ALU_SEQ_SIGNED_MD_EN
         // remainder sign follows the dividend, others follow a^b
         neg_d = sgn && ((op == OP_REM) ? a_neg : (a_neg ^ b_neg));
`endif
      end else if (active_q) begin
         cnt_d = cnt_nx;
         hi_d  = hi_nx;
         lo_d  = lo_nx;
         if (done) active_d = 1'b0;
      end
      if (flush) begin
         active_d = 1'b0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         op_q     <= OP_ADD;
         a_q      <= '0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dvs_q    <= '0;
`ifdef ALU_SEQ_SIGNED_MD_EN
         neg_q    <= 1'b0;
`endif
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dvs_q    <= dvs_d;
`ifdef ALU_SEQ_SIGNED_MD_EN
         neg_q    <= neg_d;
`endif
      end
   end

endmodule

// File: rtl/alu_seq_md.sv
// alu_seq_md
// Execute-stage ALU: single-cycle integer ops plus iterative MUL/MULHU/
// DIVU/REMU (and signed MULH/DIV/REM when ALU_SEQ_SIGNED_MD_EN is defined).
// Registered result with valid/ready on both sides.
// Ports: clk, rst_n (async active-low), flush (sync abort),
//        in_valid/in_ready, op, src_a, src_b (request side),
//        out_valid/out_ready, result, zero (response side), busy.
// Requires OP_W >= 4; codes with upper bits set are treated as unknown.
//
// state  | meaning
// S_IDLE | empty, accepting
// S_BUSY | iterative op running in the core
// S_DONE | result held; accepts a new op when out_ready
module alu_seq_md
   import alu_seq_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int OP_W  = 4,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, alu_res, core_res;
   logic             zero_q, zero_d;
   logic             in_ready_c, fire, iter, core_start, core_done;
   opc_t             opc;

   alu_seq_md_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .start (core_start),
      .op    (opc),
      .src_a (src_a),
      .src_b (src_b),
      .done  (core_done),
      .res   (core_res)
   );

   always_comb begin
      opc  = ((op >> OPC_W) == '0) ? op[OPC_W-1:0] : OP_UNK;
      iter = is_iterative(opc);

      alu_res = '0;
      case (opc)
         OP_ADD: alu_res = src_a + src_b;
         OP_SUB: alu_res = src_a - src_b;
         OP_AND: alu_res = src_a & src_b;
         OP_OR:  alu_res = src_a | src_b;
         OP_GTU: alu_res[0] = src_a > src_b;
         OP_LTU: alu_res[0] = src_a < src_b;
         OP_XOR: alu_res = src_a ^ src_b;
         OP_LT:  alu_res[0] = $signed(src_a) < $signed(src_b);
         OP_MULH, OP_DIV, OP_REM, OP_UNK: alu_res = '0;
         default: alu_res = '0;
      endcase

      in_ready_c = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
      fire       = in_valid && in_ready_c;
      core_start = fire && iter && !flush;

      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_BUSY: if (core_done) begin
            state_d  = S_DONE;
            result_d = core_res;
         end
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: ;
      endcase
      if (fire) begin
         zero_d = (src_a == src_b);
         if (iter) begin
            state_d = S_BUSY;
         end else begin
            state_d  = S_DONE;
            result_d = alu_res;
         end
      end
      // flush beats a coinciding fire; held result is left untouched
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
         zero_d   = zero_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_BUSY);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule
